// File: rtl/alu_op_queue_if.sv
// Producer-side request bus for alu_op_queue: a valid/ready handshake carrying {A, B, CMD}.
// The master modport is the producer and the slave modport is the queue.
interface alu_op_queue_if #(
    parameter int W    = 16,
    parameter int CMDW = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic [CMDW-1:0] in_cmd;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_cmd,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_cmd,
        output in_ready
    );
endinterface

// File: rtl/alu_op_queue.sv
// Issue queue for the 16-bit ALU: buffers {A,B,CMD}, sequences the accumulator clear, inserts noOp.
// Optional opcode screening (illegal_cmd port) is enabled by defining ALUQ_CMD_CHECK_EN.
module alu_op_queue #(
    parameter int DEPTH       = 8,
    parameter int W           = 16,
    parameter int CMDW        = 5,
    parameter int INIT_CYCLES = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         hold,
    alu_op_queue_if.slave                in_if,
    output logic [W-1:0]                 alu_A,
    output logic [W-1:0]                 alu_B,
    output logic [CMDW-1:0]              alu_CMD,
    output logic                         alu_RST,
    output logic                         alu_noOp,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         busy
`ifdef ALUQ_CMD_CHECK_EN
    ,
    output logic                         illegal_cmd
`endif
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int ICW = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam int EW  = 2 * W + CMDW;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [ICW-1:0]  init_cnt_q;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [EW-1:0]   head_s;
    logic [W-1:0]    alu_a_q, alu_b_q;
    logic [CMDW-1:0] alu_cmd_q;
    logic            alu_rst_q, alu_noop_q, in_ready_q, busy_q;
    logic            accept_s, cmd_bad_s, push_s, pop_s;

    // Handshake decode, pointer/count next state and FSM next state.
    always_comb begin
        accept_s = in_if.in_valid && in_ready_q;
`ifdef ALUQ_CMD_CHECK_EN
        cmd_bad_s = (in_if.in_cmd[3:0] == 4'd0) || (in_if.in_cmd[3:0] > 4'd13);
`else
        cmd_bad_s = 1'b0;
`endif
        push_s = accept_s && !cmd_bad_s && !flush;
        pop_s  = (state_q != ST_INIT) && (count_q != {CW{1'b0}}) && !hold && !flush;
        head_s = mem_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_s && !pop_s) begin
                count_d = count_q + CW'(1'b1);
            end else if (pop_s && !push_s) begin
                count_d = count_q - CW'(1'b1);
            end else begin
                count_d = count_q;
            end
        end

        if (flush) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT:           state_d = (init_cnt_q <= ICW'(1'b1)) ? ST_IDLE : ST_INIT;
                ST_IDLE, ST_ISSUE: state_d = pop_s ? ST_ISSUE : ST_IDLE;
                default:           state_d = ST_INIT;
            endcase
        end
    end

    // Queue storage; data only, validity is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {in_if.in_a, in_if.in_b, in_if.in_cmd};
        end
    end

    // FSM, pointers and all registered outputs toward the ALU and producer.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_INIT;
            init_cnt_q <= ICW'(INIT_CYCLES);
            wr_ptr_q   <= {AW{1'b0}};
            rd_ptr_q   <= {AW{1'b0}};
            count_q    <= {CW{1'b0}};
            alu_a_q    <= {W{1'b0}};
            alu_b_q    <= {W{1'b0}};
            alu_cmd_q  <= {CMDW{1'b0}};
            alu_rst_q  <= 1'b1;
            alu_noop_q <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            in_ready_q <= (count_d < CW'(DEPTH));
            busy_q     <= (state_d != ST_IDLE) || (count_d != {CW{1'b0}});
            if (flush) begin
                init_cnt_q <= ICW'(INIT_CYCLES);
                alu_cmd_q  <= {CMDW{1'b0}};
                alu_rst_q  <= 1'b1;
                alu_noop_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT: begin
                        alu_cmd_q <= {CMDW{1'b0}};
                        if (init_cnt_q <= ICW'(1'b1)) begin
                            alu_rst_q  <= 1'b0;
                            alu_noop_q <= 1'b1;
                        end else begin
                            init_cnt_q <= init_cnt_q - ICW'(1'b1);
                            alu_rst_q  <= 1'b1;
                            alu_noop_q <= 1'b0;
                        end
                    end
                    ST_IDLE, ST_ISSUE: begin
                        alu_rst_q <= 1'b0;
                        if (pop_s) begin
                            alu_a_q    <= head_s[EW-1 -: W];
                            alu_b_q    <= head_s[CMDW +: W];
                            alu_cmd_q  <= head_s[CMDW-1:0];
                            alu_noop_q <= 1'b0;
                        end else begin
                            alu_noop_q <= 1'b1;
                        end
                    end
                    default: begin
                        init_cnt_q <= ICW'(INIT_CYCLES);
                        alu_rst_q  <= 1'b1;
                        alu_noop_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef ALUQ_CMD_CHECK_EN
    logic illegal_q;

    // Sticky flag for screened opcodes; the entry itself is dropped.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            illegal_q <= 1'b0;
        end else if (flush) begin
            illegal_q <= 1'b0;
        end else if (accept_s && cmd_bad_s) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_cmd = illegal_q;
`endif

    assign in_if.in_ready = in_ready_q;
    assign alu_A          = alu_a_q;
    assign alu_B          = alu_b_q;
    assign alu_CMD        = alu_cmd_q;
    assign alu_RST        = alu_rst_q;
    assign alu_noOp       = alu_noop_q;
    assign count          = count_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_alu_op_queue.sv
// Scoreboard bench for alu_op_queue: directed pushes queue expected issues, a monitor checks each issue.
module tb_alu_op_queue;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        flush = 1'b0;
    logic        hold = 1'b0;
    logic [15:0] alu_A, alu_B;
    logic [4:0]  alu_CMD;
    logic        alu_RST, alu_noOp, busy;
    logic [3:0]  count;
`ifdef ALUQ_CMD_CHECK_EN
    logic        illegal_cmd;
`endif

    int checks   = 0;
    int failures = 0;
    logic [36:0] exp_q [$];

    alu_op_queue_if #(.W(16), .CMDW(5)) bus ();

    alu_op_queue #(.DEPTH(8), .W(16), .CMDW(5), .INIT_CYCLES(2)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .hold     (hold),
        .in_if    (bus.slave),
        .alu_A    (alu_A),
        .alu_B    (alu_B),
        .alu_CMD  (alu_CMD),
        .alu_RST  (alu_RST),
        .alu_noOp (alu_noOp),
        .count    (count),
        .busy     (busy)
`ifdef ALUQ_CMD_CHECK_EN
        ,
        .illegal_cmd (illegal_cmd)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic is_bad(input logic [4:0] c);
`ifdef ALUQ_CMD_CHECK_EN
        return (c[3:0] == 4'd0) || (c[3:0] > 4'd13);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one cycle of stimulus at the negedge; record the expected issue if it will be accepted.
    task automatic drive(input logic v, input logic h, input logic f,
                         input logic [15:0] a, input logic [15:0] b, input logic [4:0] c,
                         output logic acc);
        @(negedge CLK);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cmd   = c;
        hold         = h;
        flush        = f;
        acc = v && bus.in_ready && !f;
        if (acc && !is_bad(c)) exp_q.push_back({a, b, c});
        if (f) begin
            @(posedge CLK);
            #1;
            exp_q.delete();
        end
    endtask

    task automatic idle(input logic h);
        logic acc;
        drive(1'b0, h, 1'b0, 16'h0000, 16'h0000, 5'b00000, acc);
    endtask

    // Monitor: every issued operation must match the oldest outstanding expected entry.
    initial begin
        logic [36:0] e;
        forever begin
            @(negedge CLK);
            if (RST && !alu_RST && !alu_noOp) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: got %0h expected no issue", {alu_A, alu_B, alu_CMD});
                end else begin
                    e = exp_q.pop_front();
                    chk("issue_data", {27'd0, alu_A, alu_B, alu_CMD}, {27'd0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic [15:0] v;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'h0000;
        bus.in_b     = 16'h0000;
        bus.in_cmd   = 5'b00000;

        // Reset state and INIT sequencing
        @(negedge CLK);
        chk("rst_alu_RST", alu_RST, 1);
        chk("rst_noOp", alu_noOp, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_count", count, 0);
        chk("rst_cmd", alu_CMD, 0);
        chk("rst_busy", busy, 1);
        RST = 1'b1;
        @(negedge CLK);
        chk("init_rst_hi", alu_RST, 1);
        @(negedge CLK);
        chk("init_rst_lo", alu_RST, 0);
        chk("init_noOp", alu_noOp, 1);
        chk("init_in_ready", bus.in_ready, 1);
        chk("init_count", count, 0);
        chk("idle_busy", busy, 0);
`ifdef ALUQ_CMD_CHECK_EN
        chk("rst_illegal", illegal_cmd, 0);
`endif

        // Two back-to-back operations, one-cycle latency
        drive(1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 5'b00001, acc);
        drive(1'b1, 1'b0, 1'b0, 16'd10, 16'd20, 5'b00010, acc);
        idle(1'b0);
        chk("lat_noOp0", alu_noOp, 0);
        chk("lat_A", alu_A, 10);
        chk("lat_B", alu_B, 20);
        chk("lat_cmd1", alu_CMD, 5'b00001);
        idle(1'b0);
        chk("lat_noOp1", alu_noOp, 0);
        chk("lat_cmd2", alu_CMD, 5'b00010);
        idle(1'b0);
        chk("lat_noOp_after", alu_noOp, 1);

        // Fill under hold, ninth request refused, then drain in order
        for (int i = 1; i <= 8; i++)
            drive(1'b1, 1'b1, 1'b0, 16'(i), 16'(i + 100), 5'((i % 13) + 1), acc);
        drive(1'b1, 1'b1, 1'b0, 16'd9, 16'd109, 5'b00011, acc);
        chk("full_count", count, 8);
        chk("full_in_ready", bus.in_ready, 0);
        chk("full_noOp", alu_noOp, 1);
        idle(1'b0);
        chk("ninth_refused", count, 8);
        for (int i = 0; i < 8; i++) begin
            idle(1'b0);
            chk("drain_noOp", alu_noOp, 0);
            if (i == 0) chk("ready_after_pop", bus.in_ready, 1);
        end
        idle(1'b0);
        chk("drain_done_noOp", alu_noOp, 1);
        chk("drain_count", count, 0);

        // Full queue with continuous producer across pointer wrap
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b1, 1'b0, 16'(16'h40 + i), 16'(16'h80 + i), 5'b00101, acc);
        v = 16'h0100;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, v, ~v, 5'(5'b10000 | 5'((i % 13) + 1)), acc);
            chk("stream_count_max", count <= 4'd8, 1);
            if (acc) v = v + 16'd1;
        end
        for (int i = 0; i < 10; i++) idle(1'b0);
        chk("stream_drained", exp_q.size(), 0);

        // Flush with entries queued and a push in the same cycle
        for (int i = 0; i < 3; i++)
            drive(1'b1, 1'b1, 1'b0, 16'(16'h70 + i), 16'h0007, 5'b00110, acc);
        drive(1'b1, 1'b1, 1'b1, 16'h0077, 16'h0077, 5'b00111, acc);
        idle(1'b0);
        chk("flush_count", count, 0);
        chk("flush_rst1", alu_RST, 1);
        chk("flush_cmd", alu_CMD, 0);
        idle(1'b0);
        chk("flush_rst2", alu_RST, 1);
        idle(1'b0);
        chk("flush_rst_lo", alu_RST, 0);
        chk("flush_noOp", alu_noOp, 1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("flush_count_end", count, 0);

        // Opcode screening (queued unchanged when the check is not built in)
        drive(1'b1, 1'b0, 1'b0, 16'h0050, 16'h0060, 5'b00000, acc);
        drive(1'b1, 1'b0, 1'b0, 16'h0051, 16'h0061, 5'b01110, acc);
        idle(1'b0);
`ifdef ALUQ_CMD_CHECK_EN
        chk("illegal_set", illegal_cmd, 1);
        chk("illegal_count", count, 0);
`endif
        drive(1'b1, 1'b0, 1'b0, 16'h0052, 16'h0062, 5'b01101, acc);
        for (int i = 0; i < 4; i++) idle(1'b0);
        chk("final_drained", exp_q.size(), 0);
        chk("final_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_queue.md
Name: alu_op_queue

Overview:
- Upstream issue stage for the 16-bit ALU breadboard: buffers {A, B, CMD} operation requests from a producer and drives the ALU's A, B, CMD, RST and noOp inputs one operation per clock.
- Sequences the ALU's synchronous accumulator clear after reset or flush.
- Inserts noOp whenever the queue is empty or issue is held.
- Optionally screens illegal opcodes before they reach the ALU.

Parameters:
- DEPTH, 8, number of queued operations (power of 2, ≥2).
- W, 16, operand width; matches ALU n.
- CMDW, 5, opcode width; bit 4 selects accumulator feedback on the ALU B path.
- INIT_CYCLES, 2, cycles alu_RST is held high after reset release or flush.

Ports:
- CLK, input, 1, clock; all state updates on posedge.
- RST, input, 1, reset; asynchronous, active-low.
- flush, input, 1, synchronous: empty the queue and re-run INIT.
- hold, input, 1, suppress issue this cycle (queue contents retained).
- in_valid, input, 1, producer has an operation.
- in_ready, output, 1, queue can accept; transfer when in_valid & in_ready at posedge.
- in_a, input, W, operand A.
- in_b, input, W, operand B.
- in_cmd, input, CMDW, opcode.
- alu_A, output, W, to ALU A.
- alu_B, output, W, to ALU B.
- alu_CMD, output, CMDW, to ALU CMD.
- alu_RST, output, 1, to ALU RST (active-high accumulator clear).
- alu_noOp, output, 1, to ALU noOp.
- count, output, $clog2(DEPTH+1), entries held.
- busy, output, 1, state != IDLE or count != 0.

Behaviour:
- Reset (RST=0, async):
  - Pointers and count = 0; alu_A = alu_B = 0; alu_CMD = 0.
  - alu_RST = 1, alu_noOp = 0, in_ready = 0.
  - State = INIT with counter loaded to INIT_CYCLES.
- All alu_* outputs are registered at posedge CLK. This keeps them stable through the following negedge, when the ALU captures A/B.
- States: INIT, IDLE, ISSUE.
  - INIT: alu_RST = 1, alu_noOp = 0, alu_CMD = 0; counter decrements each cycle. When it reaches 1 → IDLE at the next edge, with alu_RST = 0 and alu_noOp = 1.
  - IDLE: alu_noOp = 1; alu_A/alu_B/alu_CMD hold their last values. If count != 0 and hold = 0 → ISSUE.
  - ISSUE: the head entry is popped into alu_A/B/CMD with alu_noOp = 0 for exactly one cycle per entry. Back-to-back issue continues while count != 0 and hold = 0; otherwise → IDLE.
- Latency: an entry pushed at edge k is issued on the alu_* outputs at edge k+1 at the earliest, when the queue is empty and not held. There is no combinational bypass.
- in_ready:
  - in_ready = (count < DEPTH) and RST released. It is registered from the post-edge count.
  - A pop in the same cycle does not raise in_ready when full.
  - Pushes are accepted during INIT and IDLE.
- Simultaneous push and pop: count unchanged, data ordering preserved (FIFO).
- Pointer wrap: modulo DEPTH; count distinguishes full from empty.
- flush=1 at an edge:
  - Pointers and count cleared; a push in the same cycle is discarded.
  - Counter reloaded and state → INIT. flush overrides hold and issue.
- hold=1 during ISSUE: the next edge outputs alu_noOp = 1, and the head entry is not popped.
- in_valid with in_ready = 0: no state change; the producer must hold its data.

Optional Feature:
- Macro: ALUQ_CMD_CHECK_EN.
- Defined:
  - Adds output illegal_cmd (1 bit, sticky, cleared by reset or flush).
  - A pushed entry with in_cmd[3:0] == 0 or > 13 is accepted (in_ready handshake completes), sets illegal_cmd, and is NOT written.
  - count is unchanged for that push.
- Undefined: no illegal_cmd port; every accepted opcode is queued and issued unchanged.

Test Plan:
- Reset then release:
  - alu_RST = 1 for 2 cycles, then alu_RST = 0 and alu_noOp = 1.
  - in_ready = 1, count = 0.
- Push {10, 20, 00001} then {10, 20, 00010} on consecutive cycles:
  - alu_A = 10, alu_B = 20, alu_CMD = 00001 at the edge after the first push; alu_CMD = 00010 at the next edge.
  - alu_noOp = 0 for those 2 cycles, then 1.
- hold = 1, push 8 entries (values 1..8):
  - count = 8 and in_ready = 0; a 9th in_valid is not accepted.
  - Release hold: entries issue 1..8 in order on 8 consecutive cycles, and in_ready returns to 1 after the first pop.
- hold = 1, fill to 8, then release hold and drive in_valid continuously:
  - count stays ≤ 8; no entry is lost or duplicated over 20 cycles.
  - Issue order matches push order across pointer wrap.
- flush with 3 entries queued plus a push in the same cycle:
  - count = 0; alu_RST = 1 for 2 cycles; no queued entry is ever issued.
- With ALUQ_CMD_CHECK_EN defined, push in_cmd = 00000 and then 01110:
  - illegal_cmd = 1 and count stays 0.
  - A subsequent push with in_cmd = 01101 issues normally.
